mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/soc_bus_pkg.sv | 16 +
 rtl/rr_pick2.sv | 21 ++
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_bus_pkg.sv
// Shared bus types for the memory arbiter: FSM state, port ids, read latency.
package soc_bus_pkg;

  typedef enum logic {
    StIdle   = 1'b0,
    StRdWait = 1'b1
  } arb_state_e;

  typedef enum logic {
    PortMcu = 1'b0,
    PortSec = 1'b1
  } port_id_e;

  localparam int unsigned RD_LATENCY = 1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, contention goes to the
// port that did not win last.
module rr_pick2
  import soc_bus_pkg::*;
(
  input  logic       valid0_i,
  input  logic       valid1_i,
  input  port_id_e   last_grant_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    if (valid0_i && valid1_i) begin
      grant_o = (last_grant_i == PortSec) ? 2'b01 : 2'b10;
    end else begin
      grant_o = {valid1_i, valid0_i};
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter onto a single memory with one-cycle read latency.
// Grants are combinational in IDLE; reads hold the arbiter for one response cycle.
module mem_arbiter
  import soc_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rstn,

  input  logic                p0_valid,
  input  logic [ADDR_W-1:0]   p0_addr,
  input  logic [DATA_W-1:0]   p0_wdata,
  input  logic [DATA_W/8-1:0] p0_wmask,
  output logic                p0_ready,
  output logic                p0_rvalid,
  output logic [DATA_W-1:0]   p0_rdata,

  input  logic                p1_valid,
  input  logic [ADDR_W-1:0]   p1_addr,
  input  logic [DATA_W-1:0]   p1_wdata,
  input  logic [DATA_W/8-1:0] p1_wmask,
  output logic                p1_ready,
  output logic                p1_rvalid,
  output logic [DATA_W-1:0]   p1_rdata,

  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  output logic                mem_rstrb,
  input  logic [DATA_W-1:0]   mem_rdata
);

  arb_state_e          state_q, state_d;
  port_id_e            last_grant_q, last_grant_d;
  port_id_e            rd_port_q, rd_port_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic                grant_en;
  logic [1:0]          grant;
  port_id_e            sel;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [DATA_W/8-1:0] sel_wmask;

  // Gating with rstn keeps ready low for the whole time reset is held.
  assign grant_en = rstn && (state_q == StIdle);

  rr_pick2 u_pick (
    .valid0_i     (p0_valid & grant_en),
    .valid1_i     (p1_valid & grant_en),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  assign sel       = port_id_e'(grant[1]);
  assign sel_addr  = grant[1] ? p1_addr  : p0_addr;
  assign sel_wdata = grant[1] ? p1_wdata : p0_wdata;
  assign sel_wmask = grant[1] ? p1_wmask : p0_wmask;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rd_port_d    = rd_port_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    p0_ready     = 1'b0;
    p1_ready     = 1'b0;
    mem_addr     = addr_q;
    mem_wdata    = wdata_q;
    mem_wmask    = '0;
    mem_rstrb    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|grant) begin
          p0_ready     = grant[0];
          p1_ready     = grant[1];
          mem_addr     = sel_addr;
          mem_wdata    = sel_wdata;
          mem_wmask    = sel_wmask;
          last_grant_d = sel;
          addr_d       = sel_addr;
          wdata_d      = sel_wdata;
          if (sel_wmask == '0) begin
            mem_rstrb = 1'b1;
            rd_port_d = sel;
            state_d   = StRdWait;
          end
        end
      end
      StRdWait: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign p0_rvalid = (state_q == StRdWait) && (rd_port_q == PortMcu);
  assign p1_rvalid = (state_q == StRdWait) && (rd_port_q == PortSec);
  assign p0_rdata  = p0_rvalid ? mem_rdata : '0;
  assign p1_rdata  = p1_rvalid ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      last_grant_q <= PortSec;
      rd_port_q    <= PortMcu;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rd_port_q    <= rd_port_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios then random traffic,
// all checked against a transaction-level model with its own memory array.
module tb_mem_arbiter;
  import soc_bus_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  logic          vld [2];
  logic [AW-1:0] adr [2];
  logic [DW-1:0] wd  [2];
  logic [3:0]    wm  [2];
  logic          hold [2];
  bit            rnd_mode;

  logic          p0_ready, p1_ready, p0_rvalid, p1_rvalid;
  logic [DW-1:0] p0_rdata, p1_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_wmask;
  logic          mem_rstrb;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) u_dut (
    .clk       (clk),
    .rstn      (rstn),
    .p0_valid  (vld[0]),
    .p0_addr   (adr[0]),
    .p0_wdata  (wd[0]),
    .p0_wmask  (wm[0]),
    .p0_ready  (p0_ready),
    .p0_rvalid (p0_rvalid),
    .p0_rdata  (p0_rdata),
    .p1_valid  (vld[1]),
    .p1_addr   (adr[1]),
    .p1_wdata  (wd[1]),
    .p1_wmask  (wm[1]),
    .p1_ready  (p1_ready),
    .p1_rvalid (p1_rvalid),
    .p1_rdata  (p1_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_rstrb (mem_rstrb),
    .mem_rdata (mem_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: memory contents, pending response, arbitration history.
  logic [DW-1:0] mem_model [16];
  int            busy_cnt;
  int            m_rd_port;
  int            m_last;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata_exp;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic new_req(input int p);
    vld[p] = ($urandom_range(0, 9) < 7);
    adr[p] = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
    wd[p]  = $urandom;
    wm[p]  = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
  endtask

  task automatic model_reset();
    busy_cnt = 0;
    m_last   = 1;
    m_addr   = '0;
    m_wdata  = '0;
  endtask

  // Called at posedge+1; checks this cycle's outputs, advances one clock.
  task automatic cycle(output int g);
    logic [DW-1:0] d;
    #1;
    if (busy_cnt > 0) begin
      g = -1;
      check_eq("busy_ready0", 32'(p0_ready), 32'd0);
      check_eq("busy_ready1", 32'(p1_ready), 32'd0);
      check_eq("rvalid0", 32'(p0_rvalid), 32'(m_rd_port == 0));
      check_eq("rvalid1", 32'(p1_rvalid), 32'(m_rd_port == 1));
      check_eq("rdata_latched", (m_rd_port == 0) ? p0_rdata : p1_rdata, m_rdata_exp);
      check_eq("rdata_other", (m_rd_port == 0) ? p1_rdata : p0_rdata, 32'd0);
      check_eq("busy_rstrb", 32'(mem_rstrb), 32'd0);
      check_eq("busy_wmask", 32'(mem_wmask), 32'd0);
      check_eq("busy_addr", mem_addr, m_addr);
    end else begin
      if (vld[0] && vld[1]) g = (m_last == 1) ? 0 : 1;
      else if (vld[0])      g = 0;
      else if (vld[1])      g = 1;
      else                  g = -1;
      check_eq("ready0", 32'(p0_ready), 32'(g == 0));
      check_eq("ready1", 32'(p1_ready), 32'(g == 1));
      check_eq("idle_rvalid", 32'({p1_rvalid, p0_rvalid}), 32'd0);
      if (g >= 0) begin
        check_eq("grant_addr", mem_addr, adr[g]);
        check_eq("grant_wdata", mem_wdata, wd[g]);
        check_eq("grant_wmask", 32'(mem_wmask), 32'(wm[g]));
        check_eq("grant_rstrb", 32'(mem_rstrb), 32'(wm[g] == 4'h0));
      end else begin
        check_eq("hold_addr", mem_addr, m_addr);
        check_eq("hold_wdata", mem_wdata, m_wdata);
        check_eq("nogrant_wmask", 32'(mem_wmask), 32'd0);
        check_eq("nogrant_rstrb", 32'(mem_rstrb), 32'd0);
      end
    end
    @(posedge clk);
    #1;
    if (busy_cnt > 0) busy_cnt--;
    if (g >= 0) begin
      m_last  = g;
      m_addr  = adr[g];
      m_wdata = wd[g];
      if (wm[g] == 4'h0) begin
        busy_cnt    = RD_LATENCY;
        m_rd_port   = g;
        m_rdata_exp = mem_model[adr[g][5:2]];
      end else begin
        d = mem_model[adr[g][5:2]];
        for (int b = 0; b < 4; b++) if (wm[g][b]) d[8*b +: 8] = wd[g][8*b +: 8];
        mem_model[adr[g][5:2]] = d;
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (p == g && !hold[p]) begin
        if (rnd_mode) new_req(p);
        else vld[p] = 1'b0;
      end else if (rnd_mode && !vld[p] && $urandom_range(0, 1) == 1) begin
        new_req(p);
      end
    end
    mem_rdata = (busy_cnt > 0) ? m_rdata_exp : $urandom;
  endtask

  task automatic do_reset();
    #1;
    rstn = 1'b0;
    #1;
    check_eq("rst_ready", 32'({p1_ready, p0_ready}), 32'd0);
    check_eq("rst_rvalid", 32'({p1_rvalid, p0_rvalid}), 32'd0);
    check_eq("rst_rstrb", 32'(mem_rstrb), 32'd0);
    check_eq("rst_wmask", 32'(mem_wmask), 32'd0);
    check_eq("rst_addr", mem_addr, 32'd0);
    check_eq("rst_wdata", mem_wdata, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    mem_rdata = $urandom;
    rstn = 1'b1;
  endtask

  task automatic set_req(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [3:0] m);
    vld[p] = 1'b1;
    adr[p] = a;
    wd[p]  = d;
    wm[p]  = m;
  endtask

  initial begin
    int g;
    int gs [6];
    int waited;
    for (int i = 0; i < 16; i++) mem_model[i] = $urandom;
    mem_model[4] = 32'hDEADBEEF;
    mem_model[8] = 32'hCAFE0123;
    rnd_mode  = 1'b0;
    hold[0]   = 1'b0;
    hold[1]   = 1'b0;
    mem_rdata = '0;
    m_rd_port = 0;
    m_rdata_exp = '0;
    // Requests pending during reset must not be granted.
    set_req(0, 32'h10, 32'h0, 4'h0);
    set_req(1, 32'h20, 32'h0, 4'h0);
    do_reset();

    // Both read from reset: p0 first, p1 two cycles later.
    cycle(g); check_eq("first_grant_p0", 32'(g), 32'd0);
    cycle(g);
    cycle(g); check_eq("p1_grant_2_later", 32'(g), 32'd1);
    cycle(g);

    // Single p0 read of 0x10 returns 0xDEADBEEF next cycle.
    set_req(0, 32'h10, 32'h0, 4'h0);
    cycle(g); check_eq("p0_read_grant", 32'(g), 32'd0);
    #1; check_eq("p0_read_data", p0_rdata, 32'hDEADBEEF);
    check_eq("p0_read_p1_rvalid", 32'(p1_rvalid), 32'd0);
    cycle(g);

    // Continuous writes from both ports alternate every cycle.
    hold[0] = 1'b1; hold[1] = 1'b1;
    set_req(0, 32'h04, 32'h11111111, 4'hF);
    set_req(1, 32'h08, 32'h00002222, 4'h3);
    for (int i = 0; i < 6; i++) cycle(gs[i]);
    for (int i = 1; i < 6; i++) check_eq("write_alternate", 32'(gs[i] != gs[i-1]), 32'd1);

    // p1 read against back-to-back p0 writes: no starvation.
    hold[1] = 1'b0;
    set_req(1, 32'h20, 32'h0, 4'h0);
    waited = 0;
    g = -1;
    while (g != 1 && waited < 4) begin
      cycle(g);
      if (g != 1) waited++;
    end
    check_eq("no_starvation", 32'(waited <= 1), 32'd1);
    hold[0] = 1'b0;
    vld[0] = 1'b0;
    cycle(g);
    cycle(g);

    // Reset during RD_WAIT drops the p1 response.
    set_req(1, 32'h24, 32'h0, 4'h0);
    cycle(g); check_eq("p1_read_grant", 32'(g), 32'd1);
    do_reset();
    check_eq("post_rst_rvalid1", 32'(p1_rvalid), 32'd0);
    set_req(0, 32'h0C, 32'h0, 4'h0);
    cycle(g); check_eq("post_rst_p0_grant", 32'(g), 32'd0);
    cycle(g);

    // Random traffic with occasional resets.
    rnd_mode = 1'b1;
    new_req(0);
    new_req(1);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      cycle(g);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
